scale_wr_burst: RTL and testbench

DDR write-burst sequencer for the scaler output path, on the AXI side of the scaled-pixel CDC FIFO. It drains packed AXI words from a first-word-fall-through FIFO and turns each frame into a run of fixed-length write bursts at an incrementing address from a per-frame base. Together with the frame-buffer rotation logic in the scale controller, it is the producer side of the scaler frame buffer that the read-side scaler stage consumes.

---
 rtl/scale_wr_burst.sv | 211 +++++++++++++++++++++
 tb/tb_scale_wr_burst.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_wr_burst.sv
// DDR write-burst sequencer: drains a FWFT FIFO into fixed-length bursts at an incrementing address.
// Optional statistics counters are built only when SCALE_WR_STAT_EN is defined.
module scale_wr_burst #(
    parameter int AXI_ADDR_WIDTH = 28,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int LEN_WIDTH      = 8,
    parameter int BURST_LEN      = 16,
    parameter int CNT_WIDTH      = 11
) (
    input  logic                      axi_clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [21:0]               frame_words,
    input  logic [AXI_DATA_WIDTH-1:0] fifo_rdata,
    input  logic [CNT_WIDTH-1:0]      fifo_count,
    output logic                      fifo_rd_en,
    output logic                      wr_burst_req,
    output logic [LEN_WIDTH-1:0]      wr_burst_len,
    output logic [AXI_ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                      wr_burst_data_req,
    output logic [AXI_DATA_WIDTH-1:0] wr_burst_data,
    input  logic                      wr_burst_finish,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic                      busy,
    output logic [15:0]               burst_cnt,
    output logic [15:0]               drop_cnt,
    output logic [2:0]                dbg_state
);

    // Handshake: wr_burst_req stays high with len/addr stable until the first
    // wr_burst_data_req; every wr_burst_data_req cycle with beat < blen pops the
    // FIFO head in the same cycle, and wr_burst_finish closes the burst.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_REQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int BPB = AXI_DATA_WIDTH / 8;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] r_cur_addr;
    logic [21:0]               r_remain;
    logic [LEN_WIDTH-1:0]      r_blen;
    logic [AXI_ADDR_WIDTH-1:0] r_burst_addr;
    logic [LEN_WIDTH-1:0]      r_beat;
    logic                      r_pending;
    logic                      r_frame_done;
    logic                      r_frame_abort;

    logic [LEN_WIDTH-1:0]      w_blen;
    logic [21:0]               w_remain_nxt;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_step;
    logic                      w_latch;
    logic                      w_abort;
    logic                      w_load;
    logic                      w_advance;
    logic                      w_set_pend;
    logic                      w_done_set;
    logic                      w_pop;
    logic                      w_new_zero;

    assign w_blen       = (r_remain >= 22'(BURST_LEN)) ? LEN_WIDTH'(BURST_LEN)
                                                       : r_remain[LEN_WIDTH-1:0];
    assign w_remain_nxt = r_remain - 22'(r_blen);
    assign w_addr_step  = AXI_ADDR_WIDTH'(r_blen) * AXI_ADDR_WIDTH'(BPB);
    assign w_new_zero   = (frame_words == 22'd0);

    always_ff @(posedge axi_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_abort     = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_set_pend  = 1'b0;
        w_done_set  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = w_new_zero ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (frame_start) begin
                    w_latch     = 1'b1;
                    w_abort     = 1'b1;
                    w_state_nxt = w_new_zero ? ST_DONE : ST_WAIT;
                end else if (fifo_count >= CNT_WIDTH'(w_blen)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_set_pend = frame_start;
                if (wr_burst_data_req) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_pop = wr_burst_data_req && (r_beat < r_blen);
                if (wr_burst_finish) begin
                    w_advance = 1'b1;
                    // A new frame takes over only once the burst in flight has closed.
                    if (r_pending || frame_start) begin
                        w_latch     = 1'b1;
                        w_abort     = 1'b1;
                        w_state_nxt = w_new_zero ? ST_DONE : ST_WAIT;
                    end else begin
                        w_state_nxt = (w_remain_nxt == 22'd0) ? ST_DONE : ST_WAIT;
                    end
                end else begin
                    w_set_pend = frame_start;
                end
            end
            ST_DONE: begin
                w_done_set  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!rst_n) begin
            r_cur_addr    <= '0;
            r_remain      <= '0;
            r_blen        <= '0;
            r_burst_addr  <= '0;
            r_beat        <= '0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_frame_done  <= w_done_set;
            r_frame_abort <= w_abort;
            if (w_latch) begin
                r_cur_addr <= base_addr;
                r_remain   <= frame_words;
            end else if (w_advance) begin
                r_cur_addr <= r_cur_addr + w_addr_step;
                r_remain   <= w_remain_nxt;
            end
            if (w_latch) begin
                r_pending <= 1'b0;
            end else if (w_set_pend) begin
                r_pending <= 1'b1;
            end
            if (w_load) begin
                r_blen       <= w_blen;
                r_burst_addr <= r_cur_addr;
                r_beat       <= '0;
            end else if (w_pop) begin
                r_beat <= r_beat + LEN_WIDTH'(1);
            end
        end
    end

`ifdef SCALE_WR_STAT_EN
    logic [15:0] r_burst_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge axi_clk) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_advance && (r_burst_cnt != 16'hFFFF)) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
            if (w_abort && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign burst_cnt = r_burst_cnt;
    assign drop_cnt  = r_drop_cnt;
`else
    assign burst_cnt = 16'd0;
    assign drop_cnt  = 16'd0;
`endif

    assign fifo_rd_en    = w_pop;
    assign wr_burst_req  = (r_state == ST_REQ);
    assign wr_burst_len  = r_blen;
    assign wr_burst_addr = r_burst_addr;
    assign wr_burst_data = fifo_rdata;
    assign frame_done    = r_frame_done;
    assign frame_abort   = r_frame_abort;
    assign busy          = (r_state != ST_IDLE);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_scale_wr_burst.sv
// Directed bench for scale_wr_burst: FWFT FIFO model, burst master driver tasks, scoreboard queue.
module tb_scale_wr_burst;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic [27:0]   base_addr;
    logic [21:0]   frame_words;
    logic [127:0]  fifo_rdata;
    logic [10:0]   fifo_count;
    logic          fifo_rd_en;
    logic          wr_burst_req;
    logic [7:0]    wr_burst_len;
    logic [27:0]   wr_burst_addr;
    logic          wr_burst_data_req;
    logic [127:0]  wr_burst_data;
    logic          wr_burst_finish;
    logic          frame_done;
    logic          frame_abort;
    logic          busy;
    logic [15:0]   burst_cnt;
    logic [15:0]   drop_cnt;
    logic [2:0]    dbg_state;

    int compared   = 0;
    int mismatched = 0;
    int fifo_fill  = 0;
    int pop_cnt    = 0;
    int done_cnt   = 0;
    int abort_cnt  = 0;
    logic [127:0] exp_q[$];

    scale_wr_burst #(
        .AXI_ADDR_WIDTH(28),
        .AXI_DATA_WIDTH(128),
        .LEN_WIDTH(8),
        .BURST_LEN(16),
        .CNT_WIDTH(11)
    ) dut (
        .axi_clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .base_addr(base_addr),
        .frame_words(frame_words),
        .fifo_rdata(fifo_rdata),
        .fifo_count(fifo_count),
        .fifo_rd_en(fifo_rd_en),
        .wr_burst_req(wr_burst_req),
        .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish),
        .frame_done(frame_done),
        .frame_abort(frame_abort),
        .busy(busy),
        .burst_cnt(burst_cnt),
        .drop_cnt(drop_cnt),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] word(input int i);
        word = {32'hC0DE0000 | 32'(i), ~32'(i), 32'(i * 3), 32'(i)};
    endfunction

    // FWFT FIFO model: head word is the next unpopped index
    assign fifo_rdata = word(pop_cnt);
    assign fifo_count = 11'(fifo_fill - pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
    end

    always @(negedge clk) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    // driver tasks
    task automatic fifo_push(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(word(fifo_fill));
            fifo_fill = fifo_fill + 1;
        end
    endtask

    task automatic start_frame(input logic [27:0] b, input logic [21:0] w);
        @(negedge clk);
        frame_start = 1'b1;
        base_addr   = b;
        frame_words = w;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic do_burst(input string name, input logic [27:0] exp_addr,
                            input logic [7:0] exp_len, input int gap_mod, input int extra,
                            input int abort_cyc, input logic [27:0] new_base,
                            input logic [21:0] new_words);
        bit got;
        int pops;
        int sent;
        int cyc;
        logic [127:0] exp;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (wr_burst_req) got = 1'b1;
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL %s req_timeout: wr_burst_req=0 after 50 cycles, want 1", name);
            return;
        end
        compared++;
        if (wr_burst_addr !== exp_addr) begin
            mismatched++;
            $display("FAIL %s addr: got %h want %h", name, wr_burst_addr, exp_addr);
        end
        compared++;
        if (wr_burst_len !== exp_len) begin
            mismatched++;
            $display("FAIL %s len: got %0d want %0d", name, wr_burst_len, exp_len);
        end
        pops = 0;
        sent = 0;
        cyc  = 0;
        while (sent < int'(exp_len) + extra && cyc < 200) begin
            wr_burst_data_req = !(gap_mod != 0 && (cyc % gap_mod) == 1);
            frame_start       = (cyc == abort_cyc);
            if (cyc == abort_cyc) begin
                base_addr   = new_base;
                frame_words = new_words;
            end
            #1;
            if (fifo_rd_en) begin
                pops++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                compared++;
                if (wr_burst_data !== exp) begin
                    mismatched++;
                    $display("FAIL %s data beat %0d: got %h want %h", name, pops, wr_burst_data, exp);
                end
            end
            if (wr_burst_data_req) sent++;
            cyc++;
            @(negedge clk);
        end
        wr_burst_data_req = 1'b0;
        frame_start       = 1'b0;
        wr_burst_finish   = 1'b1;
        @(negedge clk);
        wr_burst_finish   = 1'b0;
        compared++;
        if (pops != int'(exp_len)) begin
            mismatched++;
            $display("FAIL %s pops: got %0d want %0d", name, pops, exp_len);
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        base_addr = '0;
        frame_words = '0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({fifo_rd_en, wr_burst_req, frame_done, frame_abort, busy} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 00000",
                     {fifo_rd_en, wr_burst_req, frame_done, frame_abort, busy});
        end
        compared++;
        if ({wr_burst_len, wr_burst_addr} !== 36'h0) begin
            mismatched++;
            $display("FAIL reset_burst: len %h addr %h want 0", wr_burst_len, wr_burst_addr);
        end
        compared++;
        if ({burst_cnt, drop_cnt, dbg_state} !== 35'h0) begin
            mismatched++;
            $display("FAIL reset_stats_state: burst %h drop %h state %0d want 0",
                     burst_cnt, drop_cnt, dbg_state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int d0;
        logic [15:0] exp_b;
        fifo_push(40);
        start_frame(28'h0100000, 22'd40);
        compared++;
        if (dbg_state !== 3'd1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_wait_state: state %0d busy %b want 1 1", dbg_state, busy);
        end
        d0 = done_cnt;
        do_burst("basic_b0", 28'h0100000, 8'd16, 0, 0, -1, '0, '0);
        do_burst("basic_b1", 28'h0100100, 8'd16, 0, 0, -1, '0, '0);
        do_burst("basic_b2", 28'h0100200, 8'd8,  0, 0, -1, '0, '0);
        repeat (6) @(negedge clk);
        #1;
        compared++;
        if (done_cnt - d0 != 1) begin
            mismatched++;
            $display("FAIL basic_done: got %0d pulse cycles want 1", done_cnt - d0);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_idle: busy %b want 0", busy);
        end
`ifdef SCALE_WR_STAT_EN
        exp_b = 16'd3;
`else
        exp_b = 16'd0;
`endif
        compared++;
        if (burst_cnt !== exp_b) begin
            mismatched++;
            $display("FAIL basic_burst_cnt: got %0d want %0d", burst_cnt, exp_b);
        end
    endtask

    task automatic test_starved_stall();
        int d0;
        fifo_push(10);
        start_frame(28'h0300000, 22'd16);
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        compared++;
        if (wr_burst_req !== 1'b0 || dbg_state !== 3'd1) begin
            mismatched++;
            $display("FAIL starved_noreq: req %b state %0d want 0 1", wr_burst_req, dbg_state);
        end
        fifo_push(6);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (wr_burst_req !== 1'b1) begin
            mismatched++;
            $display("FAIL starved_req_rise: req %b want 1", wr_burst_req);
        end
        do_burst("stall", 28'h0300000, 8'd16, 3, 3, -1, '0, '0);
        repeat (6) @(negedge clk);
        #1;
        compared++;
        if (done_cnt - d0 != 1) begin
            mismatched++;
            $display("FAIL stall_done: got %0d pulse cycles want 1", done_cnt - d0);
        end
    endtask

    task automatic test_abort_data();
        int d0;
        int a0;
        logic [15:0] exp_d;
        fifo_push(32);
        start_frame(28'h0400000, 22'd32);
        d0 = done_cnt;
        a0 = abort_cnt;
        do_burst("abort_b0", 28'h0400000, 8'd16, 0, 0, 5, 28'h0200000, 22'd16);
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (abort_cnt - a0 != 1 || done_cnt - d0 != 0) begin
            mismatched++;
            $display("FAIL abort_pulse: abort %0d done %0d want 1 0", abort_cnt - a0, done_cnt - d0);
        end
        do_burst("abort_b1", 28'h0200000, 8'd16, 0, 0, -1, '0, '0);
        repeat (6) @(negedge clk);
        #1;
        compared++;
        if (done_cnt - d0 != 1 || abort_cnt - a0 != 1) begin
            mismatched++;
            $display("FAIL abort_done: done %0d abort %0d want 1 1", done_cnt - d0, abort_cnt - a0);
        end
`ifdef SCALE_WR_STAT_EN
        exp_d = 16'd1;
`else
        exp_d = 16'd0;
`endif
        compared++;
        if (drop_cnt !== exp_d) begin
            mismatched++;
            $display("FAIL abort_drop_cnt: got %0d want %0d", drop_cnt, exp_d);
        end
    endtask

    task automatic test_abort_wait();
        int a0;
        a0 = abort_cnt;
        start_frame(28'h0600000, 22'd16);
        start_frame(28'h0700000, 22'd16);
        fifo_push(16);
        do_burst("abort_wait", 28'h0700000, 8'd16, 0, 0, -1, '0, '0);
        repeat (6) @(negedge clk);
        #1;
        compared++;
        if (abort_cnt - a0 != 1) begin
            mismatched++;
            $display("FAIL abort_wait_pulse: got %0d want 1", abort_cnt - a0);
        end
    endtask

    task automatic test_zero_wrap();
        start_frame(28'h0500000, 22'd0);
        compared++;
        if (frame_done !== 1'b0 || dbg_state !== 3'd4) begin
            mismatched++;
            $display("FAIL zero_t1: done %b state %0d want 0 4", frame_done, dbg_state);
        end
        @(negedge clk);
        compared++;
        if (frame_done !== 1'b1 || wr_burst_req !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_t2: done %b req %b want 1 0", frame_done, wr_burst_req);
        end
        @(negedge clk);
        compared++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_t3: done %b busy %b want 0 0", frame_done, busy);
        end
        fifo_push(32);
        start_frame(28'hFFFFF00, 22'd32);
        do_burst("wrap_b0", 28'hFFFFF00, 8'd16, 0, 0, -1, '0, '0);
        do_burst("wrap_b1", 28'h0000000, 8'd16, 0, 0, -1, '0, '0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_starved_stall();
        test_abort_data();
        test_abort_wait();
        test_zero_wrap();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d words left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
